// File: rtl/fp16_accum_seq.sv
// Streaming FP16 reduction controller with its own 1-cycle FP16 adder.
// Optional macro FP16_ACC_INF_EN: exponent-31 operands saturate the run to a sticky signed infinity.

module fp16add_2stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  output logic [15:0] o_res
);
  logic [15:0] big, sml, res;
  logic [4:0]  diff;
  logic [31:0] sh;
  logic [13:0] mb, ms;
  logic [14:0] sum;
  logic [3:0]  lz;

  // Guard/round/sticky alignment keeps truncation exact for subtraction too.
  always_comb begin
    if (i_a[14:0] >= i_b[14:0]) begin
      big = i_a;
      sml = i_b;
    end else begin
      big = i_b;
      sml = i_a;
    end
    diff = big[14:10] - sml[14:10];
    sh   = {1'b1, sml[9:0], 21'b0} >> diff;
    mb   = {1'b1, big[9:0], 3'b000};
    ms   = sh[31:18] | {13'b0, |sh[17:0]};
    sum  = (big[15] ^ sml[15]) ? ({1'b0, mb} - {1'b0, ms}) : ({1'b0, mb} + {1'b0, ms});
    lz   = '0;
    for (int unsigned i = 0; i < 14; i++) begin
      if (sum[i]) lz = 4'(13 - i);
    end
    if (sum[14])
      res = {big[15], big[14:10] + 5'd1, sum[13:4]};
    else if (sum == '0 || big[14:10] <= {1'b0, lz})
      res = '0;
    else
      res = {big[15], big[14:10] - {1'b0, lz}, 10'((sum[13:0] << lz) >> 3)};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) o_res <= '0;
    else        o_res <= res;
  end
endmodule

module fp16_accum_seq #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_len,
  input  logic             i_valid,
  input  logic [15:0]      i_data,
  output logic             o_ready,
  output logic             o_valid,
  output logic [15:0]      o_sum,
  input  logic             i_ready,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_count
);
  typedef enum logic [1:0] {ST_IDLE, ST_ACCEPT, ST_WAIT, ST_DONE} state_t;

  state_t           state;
  logic [15:0]      acc, add_res, bypass_acc;
  logic [CNT_W-1:0] cnt, len, cnt_inc;
  logic             last, acc_zero, dat_zero, bypass;
`ifdef FP16_ACC_INF_EN
  logic             inf_q, inf_hit;
`endif

  fp16add_2stage u_add (
    .clk   (clk),
    .rst_n (rst_n),
    .i_a   (acc),
    .i_b   (i_data),
    .o_res (add_res)
  );

  assign o_sum   = acc;
  assign o_count = cnt;

  // Operands that never need the adder: zero accumulator, zero operand, or saturated run.
  always_comb begin
    cnt_inc  = cnt + 1'b1;
    last     = (cnt_inc == len);
    acc_zero = (acc[14:10] == 5'd0);
    dat_zero = (i_data[14:10] == 5'd0);
    bypass   = acc_zero || dat_zero;
    if (acc_zero) bypass_acc = dat_zero ? 16'h0000 : i_data;
    else          bypass_acc = acc;
`ifdef FP16_ACC_INF_EN
    inf_hit = (i_data[14:10] == 5'h1F);
    if (inf_q) begin
      bypass     = 1'b1;
      bypass_acc = acc;
    end else if (inf_hit) begin
      bypass     = 1'b1;
      bypass_acc = {i_data[15], 15'h7C00};
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      acc     <= '0;
      cnt     <= '0;
      len     <= '0;
      o_ready <= 1'b0;
      o_valid <= 1'b0;
      o_busy  <= 1'b0;
`ifdef FP16_ACC_INF_EN
      inf_q   <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: if (i_start) begin
          len    <= i_len;
          acc    <= '0;
          cnt    <= '0;
          o_busy <= 1'b1;
`ifdef FP16_ACC_INF_EN
          inf_q  <= 1'b0;
`endif
          if (i_len == '0) begin
            state   <= ST_DONE;
            o_valid <= 1'b1;
          end else begin
            state   <= ST_ACCEPT;
            o_ready <= 1'b1;
          end
        end
        ST_ACCEPT: if (i_valid) begin
          if (bypass) begin
            acc <= bypass_acc;
            cnt <= cnt_inc;
`ifdef FP16_ACC_INF_EN
            if (inf_hit) inf_q <= 1'b1;
`endif
            if (last) begin
              state   <= ST_DONE;
              o_ready <= 1'b0;
              o_valid <= 1'b1;
            end
          end else begin
            state   <= ST_WAIT;
            o_ready <= 1'b0;
          end
        end
        ST_WAIT: begin
          acc <= add_res;
          cnt <= cnt_inc;
          if (last) begin
            state   <= ST_DONE;
            o_valid <= 1'b1;
          end else begin
            state   <= ST_ACCEPT;
            o_ready <= 1'b1;
          end
        end
        ST_DONE: if (i_ready) begin
          state   <= ST_IDLE;
          o_valid <= 1'b0;
          o_busy  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp16_accum_seq.sv
// Scoreboard bench for fp16_accum_seq: directed cases plus randomized runs
// checked against an exact-arithmetic FP16 reference model.

module tb_fp16_accum_seq;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             i_start;
  logic [CNT_W-1:0] i_len;
  logic             i_valid;
  logic [15:0]      i_data;
  logic             o_ready;
  logic             o_valid;
  logic [15:0]      o_sum;
  logic             i_ready;
  logic             o_busy;
  logic [CNT_W-1:0] o_count;

  always #5 clk = ~clk;

  fp16_accum_seq #(.CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (i_start),
    .i_len   (i_len),
    .i_valid (i_valid),
    .i_data  (i_data),
    .o_ready (o_ready),
    .o_valid (o_valid),
    .o_sum   (o_sum),
    .i_ready (i_ready),
    .o_busy  (o_busy),
    .o_count (o_count)
  );

  typedef struct {
    logic [15:0]      sum;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] ops[$];
  int          checks = 0;
  int          failures = 0;
  int          ready_mode = 0;  // 0: always ready, 1: random, 2: held low

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference arithmetic: exact value in units of 2^-24, truncated toward zero.
  function automatic longint f2i(input logic [15:0] h);
    longint m;
    m = (longint'(1024) + longint'(h[9:0])) << (int'(h[14:10]) - 1);
    return h[15] ? -m : m;
  endfunction

  function automatic logic [15:0] i2f(input longint v);
    logic [63:0] mag;
    logic [63:0] man;
    int          p;
    int          biased;
    if (v == 0) return 16'h0000;
    mag = (v < 0) ? 64'(-v) : 64'(v);
    p = 0;
    for (int i = 0; i < 64; i++) if (mag[i]) p = i;
    biased = p - 9;
    if (biased < 1) return 16'h0000;
    man = mag >> (p - 10);
    return {v < 0, 5'(biased), man[9:0]};
  endfunction

  function automatic logic [15:0] ref_sum(input logic [15:0] q[$]);
    logic [15:0] acc;
    bit          inf;
    acc = 16'h0000;
    inf = 0;
    foreach (q[k]) begin
`ifdef FP16_ACC_INF_EN
      if (inf) continue;
      if (q[k][14:10] == 5'h1F) begin
        acc = {q[k][15], 15'h7C00};
        inf = 1;
        continue;
      end
`endif
      if (acc[14:10] == 0)       acc = (q[k][14:10] == 0) ? 16'h0000 : q[k];
      else if (q[k][14:10] != 0) acc = i2f(f2i(acc) + f2i(q[k]));
    end
    return acc;
  endfunction

  function automatic logic [15:0] rand_op();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 16'h0000;
    if (r == 1) return {1'($urandom), 5'd0, 10'($urandom)};
    return {1'($urandom), 5'($urandom_range(8, 22)), 10'($urandom)};
  endfunction

  // Monitor: while a result is presented it must match the head of the scoreboard.
  initial forever begin
    @(negedge clk);
    if (rst_n === 1'b1 && o_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result: actual sum=%0h required=no result", o_sum);
      end else begin
        check("result_sum", o_sum, sb[0].sum);
        check("result_count", o_count, sb[0].cnt);
        if (i_ready) void'(sb.pop_front());
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       i_ready = 1'b1;
      1:       i_ready = 1'($urandom_range(0, 1));
      default: i_ready = 1'b0;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (!o_busy) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check("idle_timeout", 0, 1);
  endtask

  task automatic start_run(input int len);
    wait_idle();
    i_start = 1'b1;
    i_len   = CNT_W'(len);
    tick();
    i_start = 1'b0;
  endtask

  task automatic drive_op(input logic [15:0] d, input int gap, output int stalls);
    bit ok = 0;
    repeat (gap) tick();
    i_valid = 1'b1;
    i_data  = d;
    stalls  = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (o_ready) begin
        ok = 1;
        break;
      end
      stalls++;
    end
    if (!ok) check("accept_timeout", 0, 1);
    tick();
    i_valid = 1'b0;
    i_data  = 16'($urandom);
  endtask

  task automatic run_ops(input logic [15:0] exp_sum, input int gapmax, output int stalls);
    int st;
    stalls = 0;
    sb.push_back('{exp_sum, CNT_W'(ops.size())});
    start_run(ops.size());
    foreach (ops[k]) begin
      drive_op(ops[k], $urandom_range(0, gapmax), st);
      stalls += st;
    end
  endtask

  initial begin
    int  st;
    int  st2;
    bit  ok;
    rst_n   = 1'b0;
    i_start = 1'b0;
    i_len   = '0;
    i_valid = 1'b0;
    i_data  = '0;
    i_ready = 1'b1;
    #12;
    check("reset_ready", o_ready, 0);
    check("reset_valid", o_valid, 0);
    check("reset_busy", o_busy, 0);
    check("reset_sum", o_sum, 0);
    check("reset_count", o_count, 0);
    #3 rst_n = 1'b1;
    tick();

    ops = '{16'h3C00, 16'h4000, 16'h3800};
    run_ops(16'h4300, 0, st);

    ops = '{16'h0000, 16'h3C00, 16'h0000};
    run_ops(16'h3C00, 0, st);
    check("zero_ops_no_stall", st, 0);

    sb.push_back('{16'h0000, '0});
    start_run(0);
    @(negedge clk);
    check("empty_done_next_cycle", o_valid, 1);

    ops = '{16'h3C00, 16'hBC00};
    run_ops(16'h0000, 0, st);

    // len=4 of 1.0 with gaps, a stray start pulse, and a held result
    wait_idle();
    ready_mode = 2;
    sb.push_back('{16'h4400, CNT_W'(4)});
    start_run(4);
    drive_op(16'h3C00, $urandom_range(0, 3), st);
    drive_op(16'h3C00, $urandom_range(0, 3), st);
    i_start = 1'b1;
    i_len   = CNT_W'(1);
    tick();
    i_start = 1'b0;
    drive_op(16'h3C00, $urandom_range(0, 3), st);
    drive_op(16'h3C00, $urandom_range(0, 3), st);
    ok = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (o_valid) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check("hold_valid_timeout", 0, 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("hold_valid", o_valid, 1);
      check("hold_sum", o_sum, 16'h4400);
    end
    ready_mode = 0;

    // Abort in WAIT
    start_run(2);
    drive_op(16'h3C00, 0, st);
    i_valid = 1'b1;
    i_data  = 16'h4000;
    @(negedge clk);
    check("ready_before_wait", o_ready, 1);
    tick();
    check("busy_in_wait", o_busy, 1);
    #2 rst_n = 1'b0;
    #1;
    i_valid = 1'b0;
    check("abort_ready", o_ready, 0);
    check("abort_valid", o_valid, 0);
    check("abort_busy", o_busy, 0);
    check("abort_sum", o_sum, 0);
    check("abort_count", o_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    ops = '{16'h4000, 16'h4000};
    run_ops(16'h4400, 0, st);

`ifdef FP16_ACC_INF_EN
    wait_idle();
    sb.push_back('{16'h7C00, CNT_W'(3)});
    start_run(3);
    drive_op(16'h3C00, 0, st);
    drive_op(16'h7C00, 0, st);
    drive_op(16'h4000, 0, st2);
    check("inf_last_no_stall", st2, 0);
`endif

    ready_mode = 1;
    for (int r = 0; r < 40; r++) begin
      ops = {};
      for (int k = 0; k < $urandom_range(1, 10); k++) ops.push_back(rand_op());
      run_ops(ref_sum(ops), 2, st);
    end

    ready_mode = 0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (sb.size() == 0) break;
    end
    check("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
